run_sequencer: RTL and testbench
================================

// Module: run_sequencer
// PURPOSE
//  Synthesizable boot/run controller sitting directly upstream of the Tenyr core.
//  Generates the core's reset and halt from one board reset, with independent release delays.
//  Bounds the run to a fixed number of clock periods and counts cycles and retired instructions.
//  Drives Tenyr .reset/.halt; consumes the core's per-instruction retire strobe (state == s3).
// PARAMETERS
//  RESET_CYCLES  3   rising edges after reset release before core_reset deasserts (>=1)
//  HALT_CYCLES   4   rising edges after reset release before core_halt may deassert (>=1)
//  PERIODS       64  run length in clock periods; done asserts at this edge (> both above)
//  CW            32  counter width; 2**CW must exceed PERIODS
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  reset        in   1   asynchronous, active-high reset
//  halt_req     in   1   external pause request, sampled each edge
//  insn_retire  in   1   one-cycle strobe per retired instruction from the core
//  core_reset   out  1   reset to core, registered
//  core_halt    out  1   halt to core, registered
//  done         out  1   run finished, sticky until reset
//  state        out  3   FSM state for debug: 0 BOOT, 1 WAIT, 2 RUN, 3 PAUSE, 4 DONE
//  cycle_count  out  CW  edges since reset release, saturates at PERIODS
//  insn_count   out  CW  instructions retired while running, wraps mod 2**CW
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-high. Asserting reset immediately sets:
//    state=BOOT, core_reset=1, core_halt=1, done=0, cycle_count=0, insn_count=0.
//    Reset is honoured mid-run. The sequence restarts from edge 0 after release.
//  - Edge n = nth rising edge of clk after reset deasserts. Let c' = min(cycle_count+1, PERIODS).
//  - cycle_count <= c' on every edge. It holds at PERIODS thereafter.
//  - core_reset <= (c' < RESET_CYCLES). With defaults, core_reset goes low after edge 3.
//  - done <= done | (c' == PERIODS).
//  - core_halt <= (c' < HALT_CYCLES) | halt_req | done_next, where done_next is the new done value.
//  - Release order is independent: halt may release before, with, or after reset.
//  - insn_count increments on an edge iff insn_retire & ~core_reset & ~core_halt & ~done.
//    All terms are the pre-edge registered values. insn_retire is ignored in all other cycles.
//  - FSM, next state by priority:
//      done_next                              -> DONE (absorbing until reset)
//      c' < RESET_CYCLES                      -> BOOT
//      c' < HALT_CYCLES                       -> WAIT
//      halt_req                               -> PAUSE
//      otherwise                              -> RUN
//  - PAUSE -> RUN occurs on the first edge that samples halt_req=0. No added latency.
//  - halt_req is ignored for FSM purposes in BOOT and WAIT (halt already asserted), and in DONE.
//  - Outputs change only on clk edges or reset. There are no combinational paths from inputs.
// TESTING
//  1 Defaults, halt_req=0 -> core_reset falls after edge 3; core_halt falls after edge 4;
//    done=1 and state=DONE after edge 64; cycle_count=64 and still 64 at edge 100.
//  2 Defaults, insn_retire held 1 -> insn_count=60 after edge 64 (edges 5..64 counted).
//    Value unchanged thereafter.
//  3 As 2, halt_req=1 sampled at edges 10..14 -> core_halt=1 after edges 10..14;
//    state PAUSE then RUN after edge 15; final insn_count=55.
//  4 As 2, reset pulsed 2ns mid-cycle 30 -> outputs hit reset values without a clk edge.
//    After re-release the sequence repeats exactly as scenario 2 (insn_count=60).
//  5 HALT_CYCLES=2, RESET_CYCLES=3, insn_retire=1 -> after edge 2: core_halt=0, core_reset=1,
//    state BOOT; RUN after edge 3; final insn_count=61.
//  6 halt_req=1 held from edge 60 through 70 -> done and DONE after edge 64;
//    core_halt stays 1 after halt_req drops; insn_count frozen.

Source files
------------

// File: rtl/run_sequencer_if.sv
// Control link between the run sequencer and the Tenyr core it supervises.
// The sequencer side is the master: it drives the core reset/halt and status,
// and it receives the pause request and the per-instruction retire strobe.
interface run_sequencer_if #(
   parameter int unsigned CW = 32
);
   logic          halt_req;
   logic          insn_retire;
   logic          core_reset;
   logic          core_halt;
   logic          done;
   logic [2:0]    state;
   logic [CW-1:0] cycle_count;
   logic [CW-1:0] insn_count;

   modport master (
      input  halt_req,
      input  insn_retire,
      output core_reset,
      output core_halt,
      output done,
      output state,
      output cycle_count,
      output insn_count
   );

   modport slave (
      output halt_req,
      output insn_retire,
      input  core_reset,
      input  core_halt,
      input  done,
      input  state,
      input  cycle_count,
      input  insn_count
   );
endinterface

// File: rtl/run_sequencer.sv
// Boot/run controller for the Tenyr core. Derives core reset and halt from one
// board reset with independent release points, bounds the run to PERIODS clock
// periods and counts elapsed cycles and retired instructions. Every output is
// a register; nothing from the inputs reaches an output combinationally.
module run_sequencer #(
   parameter int unsigned RESET_CYCLES = 3,
   parameter int unsigned HALT_CYCLES  = 4,
   parameter int unsigned PERIODS      = 64,
   parameter int unsigned CW           = 32
) (
   input  logic              clk,
   input  logic              reset,
   run_sequencer_if.master   bus
);

   typedef enum logic [2:0] {
      StBoot  = 3'd0,
      StWait  = 3'd1,
      StRun   = 3'd2,
      StPause = 3'd3,
      StDone  = 3'd4
   } state_e;

   localparam logic [CW-1:0] LpResetCycles = CW'(RESET_CYCLES);
   localparam logic [CW-1:0] LpHaltCycles  = CW'(HALT_CYCLES);
   localparam logic [CW-1:0] LpPeriods     = CW'(PERIODS);

   state_e        r_state;
   logic          r_core_reset;
   logic          r_core_halt;
   logic          r_done;
   logic [CW-1:0] r_cycle_count;
   logic [CW-1:0] r_insn_count;

   logic [CW-1:0] w_cycle_next;
   logic          w_done_next;
   logic          w_in_reset;
   logic          w_in_halt;
   logic          w_insn_en;

   // Next-cycle view: saturating cycle count and the release windows it implies.
   always_comb begin
      w_cycle_next = r_cycle_count;
      if (r_cycle_count < LpPeriods) begin
         w_cycle_next = r_cycle_count + CW'(1);
      end
      w_done_next = r_done | (w_cycle_next == LpPeriods);
      w_in_reset  = (w_cycle_next < LpResetCycles);
      w_in_halt   = (w_cycle_next < LpHaltCycles);
      // Only count while the core was genuinely free to run before this edge.
      w_insn_en   = bus.insn_retire & ~r_core_reset & ~r_core_halt & ~r_done;
   end

   // Sequencer FSM with all outputs and counters registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= StBoot;
         r_core_reset  <= 1'b1;
         r_core_halt   <= 1'b1;
         r_done        <= 1'b0;
         r_cycle_count <= '0;
         r_insn_count  <= '0;
      end else begin
         r_cycle_count <= w_cycle_next;
         r_done        <= w_done_next;
         r_core_reset  <= w_in_reset;
         // Done keeps the core halted even after halt_req drops.
         r_core_halt   <= w_in_halt | bus.halt_req | w_done_next;
         if (w_insn_en) begin
            r_insn_count <= r_insn_count + CW'(1);
         end
         // Priority order: done, boot window, halt window, pause, run.
         if (w_done_next) begin
            r_state <= StDone;
         end else if (w_in_reset) begin
            r_state <= StBoot;
         end else if (w_in_halt) begin
            r_state <= StWait;
         end else if (bus.halt_req) begin
            r_state <= StPause;
         end else begin
            r_state <= StRun;
         end
      end
   end

   assign bus.core_reset  = r_core_reset;
   assign bus.core_halt   = r_core_halt;
   assign bus.done        = r_done;
   assign bus.state       = r_state;
   assign bus.cycle_count = r_cycle_count;
   assign bus.insn_count  = r_insn_count;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a default instance (A) and a HALT_CYCLES=2 instance
// (B) share clock, reset and stimulus. Checkpoint table per scenario plus a
// hand-written asynchronous mid-run reset sequence.
module tb_run_sequencer;

   localparam int unsigned CW = 32;

   logic clk;
   logic rst;

   run_sequencer_if #(.CW(CW)) bus_a ();
   run_sequencer_if #(.CW(CW)) bus_b ();

   run_sequencer #(
      .RESET_CYCLES (3),
      .HALT_CYCLES  (4),
      .PERIODS      (64),
      .CW           (CW)
   ) u_dut_a (
      .clk   (clk),
      .reset (rst),
      .bus   (bus_a)
   );

   run_sequencer #(
      .RESET_CYCLES (3),
      .HALT_CYCLES  (2),
      .PERIODS      (64),
      .CW           (CW)
   ) u_dut_b (
      .clk   (clk),
      .reset (rst),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          scen;
      int          dut;
      int          edge_n;
      logic        e_rst;
      logic        e_halt;
      logic        e_done;
      logic [2:0]  e_state;
      int unsigned e_cyc;
      int unsigned e_insn;
   } row_t;

   row_t rows[$];
   int   n_checks = 0;
   int   n_errors = 0;

   localparam logic [2:0] SBoot = 3'd0, SWait = 3'd1, SRun = 3'd2, SPause = 3'd3, SDone = 3'd4;

   task automatic add_row(input int scen, input int dut, input int edge_n, input logic e_rst,
                          input logic e_halt, input logic e_done, input logic [2:0] e_state,
                          input int unsigned e_cyc, input int unsigned e_insn);
      row_t r;
      r.scen = scen; r.dut = dut; r.edge_n = edge_n; r.e_rst = e_rst; r.e_halt = e_halt;
      r.e_done = e_done; r.e_state = e_state; r.e_cyc = e_cyc; r.e_insn = e_insn;
      rows.push_back(r);
   endtask

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_dut(input string tag, input int dut, input logic e_rst, input logic e_halt,
                            input logic e_done, input logic [2:0] e_state, input int unsigned e_cyc,
                            input int unsigned e_insn);
      logic          g_rst, g_halt, g_done;
      logic [2:0]    g_state;
      logic [CW-1:0] g_cyc, g_insn;
      if (dut == 0) begin
         g_rst = bus_a.core_reset; g_halt = bus_a.core_halt; g_done = bus_a.done;
         g_state = bus_a.state; g_cyc = bus_a.cycle_count; g_insn = bus_a.insn_count;
      end else begin
         g_rst = bus_b.core_reset; g_halt = bus_b.core_halt; g_done = bus_b.done;
         g_state = bus_b.state; g_cyc = bus_b.cycle_count; g_insn = bus_b.insn_count;
      end
      check_val({tag, " core_reset"},  64'(g_rst),   64'(e_rst));
      check_val({tag, " core_halt"},   64'(g_halt),  64'(e_halt));
      check_val({tag, " done"},        64'(g_done),  64'(e_done));
      check_val({tag, " state"},       64'(g_state), 64'(e_state));
      check_val({tag, " cycle_count"}, 64'(g_cyc),   64'(e_cyc));
      check_val({tag, " insn_count"},  64'(g_insn),  64'(e_insn));
   endtask

   function automatic logic halt_for(input int scen, input int n);
      if (scen == 3) return (n >= 10 && n <= 14);
      if (scen == 6) return (n >= 60 && n <= 70);
      return 1'b0;
   endfunction

   task automatic drive(input logic hr, input logic ret);
      bus_a.halt_req = hr; bus_a.insn_retire = ret;
      bus_b.halt_req = hr; bus_b.insn_retire = ret;
   endtask

   // Reset pulse placed between clock edges; the following edge is edge 1.
   task automatic apply_reset();
      drive(1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #4 rst = 1'b0;
   endtask

   task automatic run_scenario(input int scen, input int last_edge);
      for (int n = 1; n <= last_edge; n++) begin
         drive(halt_for(scen, n), (scen != 1));
         @(posedge clk);
         #1;
         foreach (rows[i]) begin
            if (rows[i].scen == scen && rows[i].edge_n == n) begin
               check_dut($sformatf("s%0d e%0d dut%0d", scen, n, rows[i].dut), rows[i].dut,
                         rows[i].e_rst, rows[i].e_halt, rows[i].e_done, rows[i].e_state,
                         rows[i].e_cyc, rows[i].e_insn);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0);

      // Scenario 1: no retire, no pause.
      add_row(1, 0,   2, 1, 1, 0, SBoot,  2, 0);
      add_row(1, 0,   3, 0, 1, 0, SWait,  3, 0);
      add_row(1, 0,   4, 0, 0, 0, SRun,   4, 0);
      add_row(1, 0,  63, 0, 0, 0, SRun,  63, 0);
      add_row(1, 0,  64, 0, 1, 1, SDone, 64, 0);
      add_row(1, 0, 100, 0, 1, 1, SDone, 64, 0);
      add_row(1, 1,   1, 1, 1, 0, SBoot,  1, 0);
      add_row(1, 1,   2, 1, 0, 0, SBoot,  2, 0);
      add_row(1, 1,   3, 0, 0, 0, SRun,   3, 0);
      // Scenario 2: retire held high.
      add_row(2, 0,   4, 0, 0, 0, SRun,   4, 0);
      add_row(2, 0,   5, 0, 0, 0, SRun,   5, 1);
      add_row(2, 0,  64, 0, 1, 1, SDone, 64, 60);
      add_row(2, 0, 100, 0, 1, 1, SDone, 64, 60);
      add_row(2, 1,   3, 0, 0, 0, SRun,   3, 0);
      add_row(2, 1,   4, 0, 0, 0, SRun,   4, 1);
      add_row(2, 1,  64, 0, 1, 1, SDone, 64, 61);
      add_row(2, 1, 100, 0, 1, 1, SDone, 64, 61);
      // Scenario 3: pause sampled at edges 10..14.
      add_row(3, 0,   9, 0, 0, 0, SRun,    9, 5);
      add_row(3, 0,  10, 0, 1, 0, SPause, 10, 6);
      add_row(3, 0,  14, 0, 1, 0, SPause, 14, 6);
      add_row(3, 0,  15, 0, 0, 0, SRun,   15, 6);
      add_row(3, 0,  16, 0, 0, 0, SRun,   16, 7);
      add_row(3, 0,  64, 0, 1, 1, SDone,  64, 55);
      add_row(3, 1,  10, 0, 1, 0, SPause, 10, 7);
      add_row(3, 1,  64, 0, 1, 1, SDone,  64, 56);
      // Scenario 6: pause held across the done edge.
      add_row(6, 0,  59, 0, 0, 0, SRun,   59, 55);
      add_row(6, 0,  60, 0, 1, 0, SPause, 60, 56);
      add_row(6, 0,  63, 0, 1, 0, SPause, 63, 56);
      add_row(6, 0,  64, 0, 1, 1, SDone,  64, 56);
      add_row(6, 0,  71, 0, 1, 1, SDone,  64, 56);
      add_row(6, 0, 100, 0, 1, 1, SDone,  64, 56);

      // Reset values while reset is held.
      #3;
      check_dut("reset hold", 0, 1, 1, 0, SBoot, 0, 0);

      foreach (rows[i]) begin end
      apply_reset(); run_scenario(1, 100);
      apply_reset(); run_scenario(2, 100);
      apply_reset(); run_scenario(3, 100);
      apply_reset(); run_scenario(6, 100);

      // Scenario 4: asynchronous reset pulse in the middle of cycle 30.
      apply_reset();
      for (int n = 1; n <= 29; n++) begin
         drive(1'b0, 1'b1);
         @(posedge clk);
      end
      #1;
      check_val("s4 pre-pulse insn_count", 64'(bus_a.insn_count), 64'd25);
      #2 rst = 1'b1;
      #1;
      check_dut("s4 async A", 0, 1, 1, 0, SBoot, 0, 0);
      check_dut("s4 async B", 1, 1, 1, 0, SBoot, 0, 0);
      #1 rst = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         drive(1'b0, 1'b1);
         @(posedge clk);
         #1;
         if (n == 3)   check_dut("s4 rerun e3 A", 0, 0, 1, 0, SWait, 3, 0);
         if (n == 64)  check_dut("s4 rerun e64 A", 0, 0, 1, 1, SDone, 64, 60);
         if (n == 100) check_dut("s4 rerun e100 B", 1, 0, 1, 1, SDone, 64, 61);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
